// File: rtl/uart_rx_fsm_if.sv
// rtl/uart_rx_fsm_if.sv - signal bundle between UART RX sequencer, bit counter and consumer
interface uart_rx_fsm_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  RX_IN;
    logic [4:0]            Prescale;
    logic                  PAR_EN;
    logic                  PAR_TYP;
    logic [3:0]            bit_count;
    logic [4:0]            edge_count;
    logic                  Last_edge;
    logic                  count_EN;
    logic [DATA_WIDTH-1:0] P_DATA;
    logic                  Data_valid;
    logic                  Par_err;
    logic                  Stp_err;

    // Sequencer side
    modport slave (
        input  RX_IN, Prescale, PAR_EN, PAR_TYP, bit_count, edge_count, Last_edge,
        output count_EN, P_DATA, Data_valid, Par_err, Stp_err
    );

    // Environment side: serial line, configuration, counter and consumer
    modport master (
        output RX_IN, Prescale, PAR_EN, PAR_TYP, bit_count, edge_count, Last_edge,
        input  count_EN, P_DATA, Data_valid, Par_err, Stp_err
    );
endinterface

// File: rtl/uart_rx_fsm.sv
// rtl/uart_rx_fsm.sv - UART receive sequencer with mid-bit majority sampling
module uart_rx_fsm #(
    parameter int DATA_WIDTH = 8
) (
    input  logic          CLK,
    input  logic          Reset,
    uart_rx_fsm_if.slave  bus
);
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    localparam logic [3:0] LAST_BIT = 4'(DATA_WIDTH);

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
    logic                  par_bad_q, par_bad_d;
    logic                  par_en_q, par_en_d;
    logic                  par_typ_q, par_typ_d;
    logic [DATA_WIDTH-1:0] p_data_q, p_data_d;
    logic                  valid_q, valid_d;
    logic                  par_err_q, par_err_d;
    logic                  stp_err_q, stp_err_d;
    logic [2:0]            samp_q;
    logic [4:0]            mid;
    logic                  bit_val;

    // The three sample points straddle the middle of each bit period
    assign mid     = bus.Prescale >> 1;
    assign bit_val = (samp_q[0] & samp_q[1]) | (samp_q[0] & samp_q[2]) | (samp_q[1] & samp_q[2]);

    // Capture the line at edges mid-1, mid and mid+1 of the current bit
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            samp_q <= 3'b000;
        end else begin
            if (bus.edge_count == mid - 5'd1) samp_q[0] <= bus.RX_IN;
            if (bus.edge_count == mid)        samp_q[1] <= bus.RX_IN;
            if (bus.edge_count == mid + 5'd1) samp_q[2] <= bus.RX_IN;
        end
    end

    // State, datapath and registered output strobes
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            state_q   <= IDLE;
            shreg_q   <= '0;
            par_bad_q <= 1'b0;
            par_en_q  <= 1'b0;
            par_typ_q <= 1'b0;
            p_data_q  <= '0;
            valid_q   <= 1'b0;
            par_err_q <= 1'b0;
            stp_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            shreg_q   <= shreg_d;
            par_bad_q <= par_bad_d;
            par_en_q  <= par_en_d;
            par_typ_q <= par_typ_d;
            p_data_q  <= p_data_d;
            valid_q   <= valid_d;
            par_err_q <= par_err_d;
            stp_err_q <= stp_err_d;
        end
    end

    // Frame sequencing: every transition outside IDLE happens on the last edge of a bit
    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        par_bad_d = par_bad_q;
        par_en_d  = par_en_q;
        par_typ_d = par_typ_q;
        p_data_d  = p_data_q;
        valid_d   = 1'b0;
        par_err_d = 1'b0;
        stp_err_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (!bus.RX_IN) begin
                    state_d   = START;
                    par_en_d  = bus.PAR_EN;
                    par_typ_d = bus.PAR_TYP;
                    par_bad_d = 1'b0;
                end
            end
            START: begin
                if (bus.Last_edge) begin
                    // A start bit that does not hold low through mid-bit is a glitch
                    state_d = bit_val ? IDLE : DATA;
                end
            end
            DATA: begin
                if (bus.Last_edge) begin
                    // LSB arrives first, so insert at the top and shift toward bit 0
                    shreg_d = (shreg_q >> 1) | (DATA_WIDTH'(bit_val) << (DATA_WIDTH - 1));
                    if (bus.bit_count == LAST_BIT) begin
                        state_d = par_en_q ? PARITY : STOP;
                    end
                end
            end
            PARITY: begin
                if (bus.Last_edge) begin
                    par_bad_d = bit_val ^ (^shreg_q) ^ par_typ_q;
                    state_d   = STOP;
                end
            end
            STOP: begin
                if (bus.Last_edge) begin
                    state_d   = IDLE;
                    stp_err_d = ~bit_val;
                    par_err_d = par_bad_q & par_en_q;
                    if (bit_val && !(par_bad_q && par_en_q)) begin
                        valid_d  = 1'b1;
                        p_data_d = shreg_q;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Counter runs whenever a frame is in progress; dropping it in IDLE re-arms the counter
    assign bus.count_EN   = (state_q != IDLE);
    assign bus.P_DATA     = p_data_q;
    assign bus.Data_valid = valid_q;
    assign bus.Par_err    = par_err_q;
    assign bus.Stp_err    = stp_err_q;
endmodule
